// File: rtl/serial_bit_locator_if.sv
// -----------------------------------------------------------------------------
// serial_bit_locator_if
//
// Bundles the frame-control, serial-data and result signals of
// serial_bit_locator. Clock and reset are not part of the bundle.
//
// Parameters:
//   N   frame length in bits (N >= 2)
//   QW  width of Q       (derived from N, leave at default)
//   CW  width of MATCHES (derived from N, leave at default)
//
// Signals (direction as seen from the locator, i.e. the slave modport):
//   START      in   frame start / abort, synchronous
//   DATAIN     in   serial data bit
//   DIN_VALID  in   DATAIN qualifier
//   TARGET     in   bit value searched for (captured with START)
//   MODE       in   0 = first occurrence, 1 = last occurrence (captured with START)
//   Q          out  index of the located bit
//   VALID      out  completed frame had at least one match
//   NONE       out  completed frame had no match
//   MATCHES    out  number of accepted bits equal to TARGET
//   DONE       out  one-cycle pulse when results become valid
//   BUSY       out  high while bits are being accepted
// -----------------------------------------------------------------------------
interface serial_bit_locator_if #(
  parameter int N  = 8,
  parameter int QW = $clog2(N),
  parameter int CW = $clog2(N + 1)
);

  logic          START;
  logic          DATAIN;
  logic          DIN_VALID;
  logic          TARGET;
  logic          MODE;
  logic [QW-1:0] Q;
  logic          VALID;
  logic          NONE;
  logic [CW-1:0] MATCHES;
  logic          DONE;
  logic          BUSY;

  // Frame source: drives control and data, observes results.
  modport master (
    output START, DATAIN, DIN_VALID, TARGET, MODE,
    input  Q, VALID, NONE, MATCHES, DONE, BUSY
  );

  // Locator side: consumes control and data, produces results.
  modport slave (
    input  START, DATAIN, DIN_VALID, TARGET, MODE,
    output Q, VALID, NONE, MATCHES, DONE, BUSY
  );

endinterface

// File: rtl/serial_bit_locator.sv
// -----------------------------------------------------------------------------
// serial_bit_locator
//
// Scans an N-bit frame delivered one bit per qualified clock and reports the
// index of the first (MODE=0) or last (MODE=1) bit equal to TARGET, the
// number of matching bits, and whether the frame contained any match.
//
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous, active-high reset; clears every register
//   bus    slave modport of serial_bit_locator_if (control, data, results)
//
// Frame sequence: START edge -> N edges with DIN_VALID=1 -> one REPORT cycle
// with DONE=1 -> IDLE. Results are registered on the edge accepting the last
// bit and hold until the next START or RESET. START wins in every state and
// discards any bit offered on the same edge.
// -----------------------------------------------------------------------------
module serial_bit_locator #(
  parameter int N  = 8,
  parameter int QW = $clog2(N),
  parameter int CW = $clog2(N + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  serial_bit_locator_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [QW-1:0] LAST_IDX = QW'(N - 1);

  // Registered state and results
  state_t        state_q,   state_d;
  logic [QW-1:0] cnt_q,     cnt_d;
  logic          found_q,   found_d;
  logic          target_q,  target_d;
  logic          mode_q,    mode_d;
  logic [QW-1:0] q_q,       q_d;
  logic          valid_q,   valid_d;
  logic          none_q,    none_d;
  logic [CW-1:0] matches_q, matches_d;
  logic          done_q,    done_d;
  logic          busy_q,    busy_d;

  // Per-bit decode
  logic          hit_s;
  logic          last_s;

  // The incoming bit matches the target captured at frame start.
  assign hit_s  = (bus.DATAIN == target_q);
  // The bit on offer is the final bit of the frame.
  assign last_s = (cnt_q == LAST_IDX);

  // Next-state and result update: START first, then the per-state behaviour.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    target_d  = target_q;
    mode_d    = mode_q;
    q_d       = q_q;
    valid_d   = valid_q;
    none_d    = none_q;
    matches_d = matches_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    if (bus.START) begin
      // Abort whatever is in progress and open a fresh frame; a bit offered
      // on this edge is deliberately not accepted.
      state_d   = ST_SHIFT;
      cnt_d     = '0;
      found_d   = 1'b0;
      target_d  = bus.TARGET;
      mode_d    = bus.MODE;
      q_d       = '0;
      valid_d   = 1'b0;
      none_d    = 1'b0;
      matches_d = '0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_SHIFT: begin
          busy_d = 1'b1;
          if (bus.DIN_VALID) begin
            // The counter may wrap after the last bit when N is a power of
            // two; it is reloaded by the next START so the wrap is harmless.
            cnt_d = cnt_q + QW'(1);

            if (hit_s) begin
              // At most N hits per frame and CW bits hold N, so no
              // saturation logic is needed.
              matches_d = matches_q + CW'(1);
              found_d   = 1'b1;
              // First-occurrence mode keeps the earliest index; last-
              // occurrence mode overwrites on every hit.
              if (mode_q || !found_q) begin
                q_d = cnt_q;
              end else begin
                q_d = q_q;
              end
            end else begin
              matches_d = matches_q;
            end

            if (last_s) begin
              // Verdict includes the bit accepted on this very edge.
              state_d = ST_REPORT;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              valid_d = found_q | hit_s;
              none_d  = ~(found_q | hit_s);
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_REPORT: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers; reset clears everything without a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      target_q  <= 1'b0;
      mode_q    <= 1'b0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      none_q    <= 1'b0;
      matches_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      target_q  <= target_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      none_q    <= none_d;
      matches_q <= matches_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.VALID   = valid_q;
  assign bus.NONE    = none_q;
  assign bus.MATCHES = matches_q;
  assign bus.DONE    = done_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_serial_bit_locator.sv
// Directed bench for serial_bit_locator: an N=8 instance carries most of the
// sequence, an N=5 instance covers a non-power-of-two frame length.
module tb_serial_bit_locator;

  logic CLK;
  logic RESET;

  int n_vec;
  int n_err;

  // Frame 1,1,0,1,0,1,1,1 with bit 0 first
  localparam logic [7:0] FRAME_A = 8'b1110_1011;
  localparam logic [7:0] FRAME_1 = 8'b1111_1111;
  localparam logic [4:0] FRAME_5 = 5'b0_1111;

  serial_bit_locator_if #(.N(8)) bus8 ();
  serial_bit_locator_if #(.N(5)) bus5 ();

  serial_bit_locator #(.N(8)) dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  serial_bit_locator #(.N(5)) dut5 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus5.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input int q, input int v, input int nn,
                      input int m, input int dn, input int by);
    chk({tag, ".Q"},       32'(bus8.Q),       32'(q));
    chk({tag, ".VALID"},   32'(bus8.VALID),   32'(v));
    chk({tag, ".NONE"},    32'(bus8.NONE),    32'(nn));
    chk({tag, ".MATCHES"}, 32'(bus8.MATCHES), 32'(m));
    chk({tag, ".DONE"},    32'(bus8.DONE),    32'(dn));
    chk({tag, ".BUSY"},    32'(bus8.BUSY),    32'(by));
  endtask

  task automatic start8(input logic t, input logic m);
    bus8.START     = 1'b1;
    bus8.TARGET    = t;
    bus8.MODE      = m;
    bus8.DIN_VALID = 1'b0;
    tick();
    bus8.START     = 1'b0;
  endtask

  // Offer bits [from..to]; with gaps, two idle cycles follow each non-final
  // bit, with DATAIN set to the target so a wrongly accepted bit would show.
  task automatic bits8(input logic [7:0] b, input int from, input int to,
                       input bit gaps, input logic t);
    for (int k = from; k <= to; k++) begin
      bus8.DIN_VALID = 1'b1;
      bus8.DATAIN    = b[k];
      tick();
      bus8.DIN_VALID = 1'b0;
      if (gaps && k < 7) begin
        bus8.DATAIN = t;
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("gap.BUSY", 32'(bus8.BUSY), 32'd1);
          chk("gap.DONE", 32'(bus8.DONE), 32'd0);
        end
      end
    end
    bus8.DIN_VALID = 1'b0;
  endtask

  task automatic frame8(input string tag, input logic [7:0] b, input logic t,
                        input logic m, input bit gaps, input int q, input int v,
                        input int nn, input int mm);
    start8(t, m);
    chk8({tag, ".start"}, 0, 0, 0, 0, 0, 1);
    bits8(b, 0, 7, gaps, t);
    chk8({tag, ".done"}, q, v, nn, mm, 1, 0);
    tick();
    chk8({tag, ".hold"}, q, v, nn, mm, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    bus8.START = 1'b0; bus8.DATAIN = 1'b0; bus8.DIN_VALID = 1'b0;
    bus8.TARGET = 1'b0; bus8.MODE = 1'b0;
    bus5.START = 1'b0; bus5.DATAIN = 1'b0; bus5.DIN_VALID = 1'b0;
    bus5.TARGET = 1'b0; bus5.MODE = 1'b0;

    #2;
    chk8("reset", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk8("idle", 0, 0, 0, 0, 0, 0);

    // Main function, several target/mode combinations
    frame8("a_t0_first", FRAME_A, 1'b0, 1'b0, 1'b0, 2, 1, 0, 2);
    frame8("a_t0_last",  FRAME_A, 1'b0, 1'b1, 1'b0, 4, 1, 0, 2);
    frame8("a_t1_first", FRAME_A, 1'b1, 1'b0, 1'b0, 0, 1, 0, 6);
    frame8("ones_t0",    FRAME_1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    frame8("ones_t1",    FRAME_1, 1'b1, 1'b1, 1'b0, 7, 1, 0, 8);
    frame8("a_gaps",     FRAME_A, 1'b0, 1'b0, 1'b1, 2, 1, 0, 2);

    // Abort after 5 bits; the bit offered on the START edge is dropped
    start8(1'b0, 1'b0);
    bits8(FRAME_A, 0, 4, 1'b0, 1'b0);
    chk8("abort.mid", 2, 0, 0, 2, 0, 1);
    bus8.START = 1'b1; bus8.TARGET = 1'b0; bus8.MODE = 1'b0;
    bus8.DIN_VALID = 1'b1; bus8.DATAIN = 1'b0;
    tick();
    bus8.START = 1'b0; bus8.DIN_VALID = 1'b0;
    chk8("abort.clr", 0, 0, 0, 0, 0, 1);
    bits8(FRAME_A, 0, 6, 1'b0, 1'b0);
    chk8("abort.b6", 2, 0, 0, 2, 0, 1);
    bits8(FRAME_A, 7, 7, 1'b0, 1'b0);
    chk8("abort.done", 2, 1, 0, 2, 1, 0);
    tick();

    // START during the REPORT cycle
    start8(1'b1, 1'b1);
    bits8(FRAME_1, 0, 7, 1'b0, 1'b1);
    chk8("rep.done", 7, 1, 0, 8, 1, 0);
    bus8.START = 1'b1; bus8.TARGET = 1'b0; bus8.MODE = 1'b0;
    tick();
    bus8.START = 1'b0;
    chk8("rep.restart", 0, 0, 0, 0, 0, 1);
    bits8(FRAME_A, 0, 7, 1'b0, 1'b0);
    chk8("rep.frame", 2, 1, 0, 2, 1, 0);
    tick();

    // Asynchronous reset mid-frame
    start8(1'b1, 1'b1);
    bits8(FRAME_A, 0, 2, 1'b0, 1'b1);
    chk8("rst.mid", 1, 0, 0, 2, 0, 1);
    bus8.DIN_VALID = 1'b1; bus8.DATAIN = 1'b1;
    #3;
    RESET = 1'b1;
    #1;
    chk8("rst.async", 0, 0, 0, 0, 0, 0);
    #2;
    RESET = 1'b0;
    tick();
    tick();
    chk8("rst.after", 0, 0, 0, 0, 0, 0);
    bus8.DIN_VALID = 1'b0;

    // N=5 instance: 1,1,1,1,0 with TARGET=0
    bus5.START = 1'b1; bus5.TARGET = 1'b0; bus5.MODE = 1'b0;
    tick();
    bus5.START = 1'b0;
    chk("n5.BUSY0", 32'(bus5.BUSY), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus5.DIN_VALID = 1'b1;
      bus5.DATAIN    = FRAME_5[k];
      tick();
      if (k == 3) begin
        chk("n5.early_DONE", 32'(bus5.DONE), 32'd0);
      end
    end
    bus5.DIN_VALID = 1'b0;
    chk("n5.Q",       32'(bus5.Q),       32'd4);
    chk("n5.VALID",   32'(bus5.VALID),   32'd1);
    chk("n5.NONE",    32'(bus5.NONE),    32'd0);
    chk("n5.MATCHES", 32'(bus5.MATCHES), 32'd1);
    chk("n5.DONE",    32'(bus5.DONE),    32'd1);
    chk("n5.BUSY",    32'(bus5.BUSY),    32'd0);
    tick();
    chk("n5.DONE_end", 32'(bus5.DONE),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_bit_locator.md
# serial_bit_locator

Parametrised serial frame scanner: accepts an N-bit frame one bit per qualified clock and reports the index of the first or last bit equal to a selectable target value. It also reports the number of matching bits and flags frames with no match. It sits behind a serial front end and is the generalised replacement for the fixed 8-bit, first-zero detector. Unlike that detector, it gives explicit "no match" reporting instead of a forced index.

## Interface
Parameters:
- N, 8: frame length in bits, N >= 2.
- QW, $clog2(N): width of Q (derived; do not override).
- CW, $clog2(N+1): width of MATCHES (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock; the block's only clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  synchronous frame start/abort; clears results and begins a new frame.
- DATAIN  in  1  serial data bit.
- DIN_VALID  in  1  DATAIN qualifier; a bit is accepted only when high in SHIFT.
- TARGET  in  1  bit value searched for; captured on the START edge.
- MODE  in  1  0 = first occurrence, 1 = last occurrence; captured on the START edge.
- Q  out  QW  index of the located bit (0 = first accepted bit).
- VALID  out  1  at least one match in the completed frame.
- NONE  out  1  frame completed with zero matches.
- MATCHES  out  CW  count of accepted bits equal to TARGET.
- DONE  out  1  one-cycle pulse; results are valid from this cycle on.
- BUSY  out  1  high while in SHIFT.

## Operation
- FSM states:
  - IDLE: waits for START.
  - SHIFT: accepting bits.
  - REPORT: one cycle with DONE=1, then returns to IDLE.
- START (any state) on a rising edge:
  - state <= SHIFT; bit counter <= 0.
  - Q, VALID, NONE, MATCHES <= 0.
  - TARGET and MODE are latched.
- START has priority over everything else. A bit presented with DIN_VALID on the START edge is discarded.
- In SHIFT, on each edge with DIN_VALID=1, accept DATAIN as bit k (k = counter value), then counter += 1. If DATAIN == latched TARGET:
  - MATCHES += 1.
  - MODE=0: Q <= k only if this is the first match of the frame.
  - MODE=1: Q <= k on every match.
  - Set an internal found flag.
- Accepting bit N-1 moves the FSM to REPORT. On that same edge VALID <= found (including this bit) and NONE <= !found. With no match, Q remains 0.
- DIN_VALID is ignored in IDLE and REPORT. DATAIN is ignored when DIN_VALID=0.
- Results hold after REPORT until the next START or RESET.
- MATCHES saturates by construction: its maximum is N and CW bits hold N.
- VALID and NONE are never both 1. Both are 0 before a frame completes.

## Timing
- RESET asserted:
  - All outputs drop to 0 immediately, without waiting for a clock edge.
  - State IDLE; counter and found flag cleared.
  - The latched TARGET and MODE reset to 0.
- RESET released: normal operation resumes at the first rising edge.
- BUSY rises in the cycle after the START edge and falls in the cycle after the edge that accepts bit N-1.
- Latency: results and DONE are registered on the edge accepting bit N-1, so they are visible in the following cycle. DONE lasts exactly one cycle.
- Minimum frame time is N+1 edges after START (START edge plus N accepted bits) when DIN_VALID is held high.
- START in the REPORT cycle: DONE drops and a new frame begins on that edge.
- RESET mid-frame discards the partial frame. A new START is required.

## Test plan
- Bits 1,1,0,1,0,1,1,1 (bit 0 first) with N=8, TARGET=0, MODE=0, DIN_VALID held high -> Q=2, VALID=1, NONE=0, MATCHES=2. DONE is high for one cycle immediately after the 8th bit edge.
- Same frame with MODE=1 -> Q=4, MATCHES=2. Repeat with TARGET=1, MODE=0 -> Q=0, MATCHES=6.
- Bits all 1, TARGET=0 -> NONE=1, VALID=0, Q=0, MATCHES=0. Bits all 1, TARGET=1, MODE=1 -> Q=7, MATCHES=8 (checks the CW width).
- DIN_VALID toggled 1,0,0,1,... across the frame -> identical results to the gap-free case. BUSY stays high throughout and DONE does not fire early.
- START after 5 accepted bits, with DIN_VALID=1 and DATAIN=0 on the START edge -> that bit is dropped and outputs clear. Results reflect only the new 8-bit frame.
- RESET pulsed asynchronously between clock edges mid-frame -> all outputs 0 at once and BUSY=0. An N=5 instance with bits 1,1,1,1,0, TARGET=0 -> Q=4, VALID=1.
